conv_frame_ctrl: RTL and testbench
==================================

// Module: conv_frame_ctrl
// PURPOSE
//  Frame sequencer for the streaming 3x3 convolution datapath. Accepts one frame of
//  IMAGE_WIDTH x IMAGE_HEIGHT pixels from an upstream valid/ready source and drives
//  the convolution's pixel/valid inputs. It tags which convolution results are
//  full-interior windows and emits only those, with start-of-frame and end-of-line
//  markers. It runs a start/busy/done frame FSM around the datapath.
// PARAMETERS
//  PIXEL_WIDTH   8  pixel bit width (input and output)
//  IMAGE_WIDTH   8  pixels per line; >= 3
//  IMAGE_HEIGHT  8  lines per frame; >= 3
//  CONV_LATENCY  2  clocks from conv_valid high to the matching result on conv_pixel; >= 1
// PORTS
//  clk         in   1            clock; all logic on posedge
//  rst         in   1            synchronous reset, active-high
//  start       in   1            pulse; begins a frame when the FSM is IDLE
//  abort       in   1            pulse; drops the current frame
//  busy        out  1            high in RUN or FLUSH
//  done        out  1            one-cycle pulse at frame completion
//  s_valid     in   1            upstream pixel valid
//  s_ready     out  1            upstream ready
//  s_pixel     in   PIXEL_WIDTH  upstream pixel
//  conv_valid  out  1            to datapath valid_in
//  conv_pixel_in  out  PIXEL_WIDTH  to datapath pixel_in
//  conv_pixel  in   PIXEL_WIDTH  result from datapath pixel_out
//  m_valid     out  1            interior result valid
//  m_pixel     out  PIXEL_WIDTH  interior result
//  m_sof       out  1            first interior result of the frame
//  m_eol       out  1            last interior result of a line
// BEHAVIOUR
//  - Reset: state=IDLE. Counters x,y = 0. Tag pipe cleared.
//    All outputs = 0, including s_ready, busy, done, conv_valid and m_*.
//  - FSM states: IDLE, RUN, FLUSH, DONE.
//    IDLE->RUN on start. start in any other state is ignored.
//    RUN->FLUSH on the cycle the last pixel (x=W-1, y=H-1) is accepted.
//    FLUSH lasts exactly CONV_LATENCY cycles, then goes to DONE.
//    DONE lasts 1 cycle with done=1, then goes to IDLE.
//  - Handshake: s_ready = (state==RUN). A pixel is accepted when s_valid && s_ready.
//    conv_valid = accept, combinational. conv_pixel_in = s_pixel, combinational.
//  - Position counters: x increments on each accept. At x=W-1, x wraps to 0 and y increments.
//    Counters are held at 0 outside RUN.
//  - Tag for the accepted pixel: interior = (x>=2 && y>=2); sof = (x==2 && y==2); eol = (x==W-1).
//    Tags go into a CONV_LATENCY-deep shift register that advances every clock.
//    A bubble (no accept) shifts in all-zero tags.
//  - Output: m_valid / m_sof / m_eol = tag pipe tail. m_pixel = conv_pixel when m_valid, else 0.
//    Output is registered where the tail is registered; there is no downstream backpressure.
//  - Per frame: exactly (W-2)*(H-2) m_valid pulses, one m_sof, and (H-2) m_eol.
//  - Upstream stalls (s_valid=0) insert gaps but never change the count or the ordering.
//  - abort (any state except IDLE), registered: the next state is IDLE.
//    Counters and tag pipe are cleared that cycle. s_ready=0 from the next cycle. done is not pulsed.
//    abort outranks start and the FSM transitions in the same cycle.
//  - rst mid-frame behaves like abort but also clears the optional statistics.
//  - start together with abort while IDLE: stays IDLE.
// CONFIGURATION
//  CONV_FRAME_CTRL_STATS_EN defined: adds output ports
//   stat_frames  out 16  completed frames (increments in DONE, saturates at 0xFFFF)
//   stat_stalls  out 16  RUN cycles with s_valid=0 (saturating)
//   Both counters are cleared by rst only; abort does not clear them.
//  Not defined: those ports and their counters are absent. All other behaviour is identical.
// TESTING
//  1. W=H=8, LAT=2, start, then 64 back-to-back pixels with value = index
//     -> s_ready high for 64 cycles; 36 m_valid; m_sof with the 1st; m_eol every 6th;
//        done 1 cycle, exactly LAT+1 clocks after the last accept; busy low after done.
//  2. Same frame with s_valid toggling 1/0 every cycle
//     -> still 36 outputs, same m_pixel sequence as test 1; stat_stalls=63 with STATS_EN.
//  3. Abort after pixel 20 is accepted
//     -> IDLE next cycle; no done; the m_valid in flight is suppressed.
//        A following start plus a full frame gives 36 outputs with correct m_sof.
//  4. start pulsed during RUN and FLUSH -> ignored; the frame completes normally, one done.
//  5. rst asserted at pixel 40, then released
//     -> all outputs 0 while in reset; IDLE; stat_frames=0.
//        Two full frames afterwards -> stat_frames=2.
//  6. W=3, H=3 minimum size -> 9 accepts, exactly 1 m_valid with both m_sof=1 and m_eol=1.

Source files
------------

// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if: upstream stream, convolution datapath taps and interior-result stream
interface conv_frame_ctrl_if #(parameter int PIXEL_WIDTH = 8);
    logic                   s_valid;
    logic                   s_ready;
    logic [PIXEL_WIDTH-1:0] s_pixel;
    logic                   conv_valid;
    logic [PIXEL_WIDTH-1:0] conv_pixel_in;
    logic [PIXEL_WIDTH-1:0] conv_pixel;
    logic                   m_valid;
    logic [PIXEL_WIDTH-1:0] m_pixel;
    logic                   m_sof;
    logic                   m_eol;
    modport slave (
        input  s_valid, s_pixel, conv_pixel,
        output s_ready, conv_valid, conv_pixel_in, m_valid, m_pixel, m_sof, m_eol
    );
    modport master (
        output s_valid, s_pixel, conv_pixel,
        input  s_ready, conv_valid, conv_pixel_in, m_valid, m_pixel, m_sof, m_eol
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer for the 3x3 convolution datapath, emits interior windows only.
// Define CONV_FRAME_CTRL_STATS_EN to add the stat_frames / stat_stalls counters.
module conv_frame_ctrl #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int CONV_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
`ifdef CONV_FRAME_CTRL_STATS_EN
    conv_frame_ctrl_if.slave bus,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_stalls
`else
    conv_frame_ctrl_if.slave bus
`endif
);
    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int YW = $clog2(IMAGE_HEIGHT);
    localparam int FW = $clog2(CONV_LATENCY + 1);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] fcnt;
    logic [CONV_LATENCY-1:0][2:0] tag_q;
    logic [2:0] tag_d, tail;
    logic ready, accept, x_last, y_last, interior;
    assign accept   = bus.s_valid && ready;
    assign x_last   = x == XW'(IMAGE_WIDTH - 1);
    assign y_last   = y == YW'(IMAGE_HEIGHT - 1);
    assign interior = x >= XW'(2) && y >= YW'(2);
    // tag = {interior, sof, eol}; sof/eol only ever mark interior windows
    assign tag_d = accept ? {interior, interior && x == XW'(2) && y == YW'(2), interior && x_last} : 3'b000;
    assign tail  = tag_q[CONV_LATENCY-1];
    assign bus.s_ready       = ready;
    assign bus.conv_valid    = accept;
    assign bus.conv_pixel_in = bus.s_pixel;
    assign bus.m_valid       = tail[2];
    assign bus.m_sof         = tail[1];
    assign bus.m_eol         = tail[0];
    assign bus.m_pixel       = tail[2] ? bus.conv_pixel : PIXEL_WIDTH'(0);
    always_comb begin
        state_d = abort ? IDLE :
                  state == IDLE  ? (start ? RUN : IDLE) :
                  state == RUN   ? (accept && x_last && y_last ? FLUSH : RUN) :
                  state == FLUSH ? (fcnt == FW'(CONV_LATENCY - 1) ? DONE : FLUSH) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b0;
            fcnt  <= '0;
            x     <= '0;
            y     <= '0;
            tag_q <= '0;
        end else begin
            state <= state_d;
            busy  <= state_d == RUN || state_d == FLUSH;
            done  <= state_d == DONE;
            ready <= state_d == RUN;
            fcnt  <= state == FLUSH ? fcnt + 1'b1 : '0;
            x     <= state_d != RUN ? '0 : accept ? (x_last ? '0 : x + 1'b1) : x;
            y     <= state_d != RUN ? '0 : accept && x_last ? y + 1'b1 : y;
            tag_q <= abort ? '0 : (3 * CONV_LATENCY)'({tag_q, tag_d});
        end
    end
`ifdef CONV_FRAME_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= '0;
            stat_stalls <= '0;
        end else begin
            if (state == DONE && stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
            if (state == RUN && !bus.s_valid && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: table-driven frames plus abort, reset and 3x3 sequences, scoreboard on m_* outputs
module tb_conv_frame_ctrl;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic rst, start, start3, abort, busy, done, busy3, done3;
    always #5 clk = ~clk;
    conv_frame_ctrl_if #(.PIXEL_WIDTH(8)) b ();
    conv_frame_ctrl_if #(.PIXEL_WIDTH(8)) b3 ();
`ifdef CONV_FRAME_CTRL_STATS_EN
    logic [15:0] stat_frames, stat_stalls, sf3, ss3;
`endif
    conv_frame_ctrl #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .CONV_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
`ifdef CONV_FRAME_CTRL_STATS_EN
        .stat_frames(stat_frames), .stat_stalls(stat_stalls),
`endif
        .bus(b)
    );
    conv_frame_ctrl #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3), .CONV_LATENCY(LAT)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort), .busy(busy3), .done(done3),
`ifdef CONV_FRAME_CTRL_STATS_EN
        .stat_frames(sf3), .stat_stalls(ss3),
`endif
        .bus(b3)
    );
    // stand-in datapath: result = pixel + 100, LAT clocks after conv_valid
    logic [LAT-1:0][7:0] p8, p3;
    always @(posedge clk) begin
        p8 <= {p8[0], b.conv_pixel_in + 8'd100};
        p3 <= {p3[0], b3.conv_pixel_in + 8'd100};
    end
    assign b.conv_pixel  = p8[LAT-1];
    assign b3.conv_pixel = p3[LAT-1];

    typedef struct packed {logic [7:0] pix; logic sof; logic eol;} exp_t;
    typedef struct {int stall; int poke; int outs; int sofs; int eols; int dones; int stalls;} vec_t;
    exp_t q8[$], q3[$];
    int checks = 0, errors = 0, cyc = 0;
    int n_out = 0, n_sof = 0, n_eol = 0, n_done = 0, lacc = 0, done_cyc = 0;
    int n3_out = 0, n3_sof = 0, n3_eol = 0, n3_done = 0, n3_acc = 0;
    int o0, f0, e0, d0, st0;
    int pidx = 0, pidx3 = 0;
    logic pres = 1'b0, pres3 = 1'b0;
    vec_t tv[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t expect_of(input int i, input int w);
        exp_t e;
        e.pix = 8'(i + 100);
        e.sof = (i % w == 2) && (i / w == 2);
        e.eol = (i % w == w - 1) && (i / w >= 2);
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (pres) begin
            chk("s_ready", int'(b.s_ready), 1);
            chk("conv_valid", int'(b.conv_valid), 1);
            chk("conv_pixel_in", int'(b.conv_pixel_in), pidx % 256);
            if (pidx % 8 >= 2 && pidx / 8 >= 2) q8.push_back(expect_of(pidx, 8));
            lacc = cyc;
        end
        if (pres3) begin
            chk("3x3 s_ready", int'(b3.s_ready), 1);
            if (pidx3 % 3 >= 2 && pidx3 / 3 >= 2) q3.push_back(expect_of(pidx3, 3));
            n3_acc++;
        end
        if (b.m_valid) begin
            n_out++;
            n_sof += int'(b.m_sof);
            n_eol += int'(b.m_eol);
            if (q8.size() == 0) chk("m_valid spurious", int'(b.m_valid), 0);
            else begin
                e = q8.pop_front();
                chk("m_pixel", int'(b.m_pixel), int'(e.pix));
                chk("m_sof", int'(b.m_sof), int'(e.sof));
                chk("m_eol", int'(b.m_eol), int'(e.eol));
            end
        end else chk("m_idle", int'({b.m_sof, b.m_eol, b.m_pixel}), 0);
        if (b3.m_valid) begin
            n3_out++;
            n3_sof += int'(b3.m_sof);
            n3_eol += int'(b3.m_eol);
            if (q3.size() == 0) chk("3x3 m_valid spurious", int'(b3.m_valid), 0);
            else begin
                e = q3.pop_front();
                chk("3x3 m_pixel", int'(b3.m_pixel), int'(e.pix));
                chk("3x3 m_sof", int'(b3.m_sof), int'(e.sof));
                chk("3x3 m_eol", int'(b3.m_eol), int'(e.eol));
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (done3) n3_done++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_frame(input int stall, input int poke, input int cut_at, input bit use_rst);
        o0 = n_out; f0 = n_sof; e0 = n_eol; d0 = n_done; st0 = 0;
`ifdef CONV_FRAME_CTRL_STATS_EN
        st0 = int'(stat_stalls);
`endif
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b.s_valid = 1'b1;
            b.s_pixel = 8'(i);
            pres = 1'b1;
            pidx = i;
            start = poke != 0 && i % 16 == 5;
            cycle();
            start = 1'b0;
            pres = 1'b0;
            b.s_valid = 1'b0;
            if (i == cut_at) begin
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
                cycle();
                abort = 1'b0;
                return;
            end
            if (stall != 0 && i < 63) cycle();
        end
        start = poke != 0;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 20 && n_done == d0; k++) cycle();
    endtask

    task automatic frame_checks(input vec_t v);
        chk("frame outputs", n_out - o0, v.outs);
        chk("frame sof", n_sof - f0, v.sofs);
        chk("frame eol", n_eol - e0, v.eols);
        chk("frame done", n_done - d0, v.dones);
        chk("done latency", done_cyc - lacc, LAT + 1);
        chk("busy after done", int'(busy), 0);
        chk("scoreboard drained", q8.size(), 0);
`ifdef CONV_FRAME_CTRL_STATS_EN
        chk("stat_stalls delta", int'(stat_stalls) - st0, v.stalls);
`endif
    endtask

    initial begin
        tv[0] = '{stall: 0, poke: 0, outs: 36, sofs: 1, eols: 6, dones: 1, stalls: 0};
        tv[1] = '{stall: 1, poke: 0, outs: 36, sofs: 1, eols: 6, dones: 1, stalls: 63};
        tv[2] = '{stall: 0, poke: 1, outs: 36, sofs: 1, eols: 6, dones: 1, stalls: 0};
        rst = 1'b1; start = 1'b0; start3 = 1'b0; abort = 1'b0;
        b.s_valid = 1'b1; b.s_pixel = 8'h55;
        b3.s_valid = 1'b1; b3.s_pixel = 8'h55;
        repeat (3) cycle();
        chk("reset outs", int'({busy, done, b.s_ready, b.conv_valid, b.m_valid, b.m_sof, b.m_eol, b.m_pixel}), 0);
        chk("3x3 reset outs", int'({busy3, done3, b3.s_ready, b3.conv_valid, b3.m_valid, b3.m_sof, b3.m_eol, b3.m_pixel}), 0);
        rst = 1'b0; b.s_valid = 1'b0; b3.s_valid = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            run_frame(tv[k].stall, tv[k].poke, -1, 1'b0);
            frame_checks(tv[k]);
        end
        // abort right after pixel 20: its result must never appear
        run_frame(0, 0, 20, 1'b0);
        chk("abort busy", int'(busy), 0);
        chk("abort s_ready", int'(b.s_ready), 0);
        repeat (6) cycle();
        chk("abort no done", n_done - d0, 0);
        chk("abort suppressed", q8.size(), 1);
        q8.delete();
        run_frame(0, 0, -1, 1'b0);
        frame_checks(tv[0]);
`ifdef CONV_FRAME_CTRL_STATS_EN
        chk("stat_frames pre-rst", int'(stat_frames), 4);
`endif
        // reset mid-frame at pixel 40
        run_frame(0, 0, 40, 1'b1);
        chk("mid rst outs", int'({busy, done, b.s_ready, b.conv_valid, b.m_valid, b.m_sof, b.m_eol, b.m_pixel}), 0);
`ifdef CONV_FRAME_CTRL_STATS_EN
        chk("stat_frames after rst", int'(stat_frames), 0);
`endif
        cycle();
        rst = 1'b0;
        q8.delete();
        cycle();
        chk("idle after rst", int'({busy, b.s_ready}), 0);
        repeat (2) begin
            run_frame(0, 0, -1, 1'b0);
            frame_checks(tv[0]);
        end
`ifdef CONV_FRAME_CTRL_STATS_EN
        chk("stat_frames two frames", int'(stat_frames), 2);
`endif
        // minimum 3x3 frame: a single window carrying both markers
        o0 = n3_out; f0 = n3_sof; e0 = n3_eol; d0 = n3_done; st0 = n3_acc;
        start3 = 1'b1;
        cycle();
        start3 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b3.s_valid = 1'b1;
            b3.s_pixel = 8'(i);
            pres3 = 1'b1;
            pidx3 = i;
            cycle();
            pres3 = 1'b0;
            b3.s_valid = 1'b0;
        end
        for (int k = 0; k < 20 && n3_done == d0; k++) cycle();
        chk("3x3 accepts", n3_acc - st0, 9);
        chk("3x3 outputs", n3_out - o0, 1);
        chk("3x3 sof", n3_sof - f0, 1);
        chk("3x3 eol", n3_eol - e0, 1);
        chk("3x3 done", n3_done - d0, 1);
        chk("3x3 busy after done", int'(busy3), 0);
        chk("3x3 scoreboard drained", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
